// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM state encoding and requester IDs shared by the arbiter and its picker.
// Each grant state has the same encoding as its requester ID, so the state register is also the last-grant ID.
package ram_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GV = 2'd1, GC = 2'd2, GL = 2'd3} state_t;
    localparam logic [1:0] ID_N = 2'd0;
    localparam logic [1:0] ID_V = 2'd1;
    localparam logic [1:0] ID_C = 2'd2;
    localparam logic [1:0] ID_L = 2'd3;
endpackage

// File: rtl/ram_pick.sv
// ram_pick: combinational priority picker; video > CPU > loader, with the loader promoted over the CPU when starved.
module ram_pick
    import ram_arbiter_pkg::*;
(
    input  logic       i_vreq,
    input  logic       i_creq,
    input  logic       i_lreq,
    input  logic [1:0] i_last,
    input  logic       i_starve,
    output logic [1:0] o_win
);
    logic w_ev, w_ec, w_el;
    // The requester acked this cycle still shows req high, so it sits out one edge.
    assign w_ev  = i_vreq && i_last != ID_V;
    assign w_ec  = i_creq && i_last != ID_C;
    assign w_el  = i_lreq && i_last != ID_L;
    assign o_win = w_ev ? ID_V : (i_starve && w_el) ? ID_L : w_ec ? ID_C : w_el ? ID_L : ID_N;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between video reads, CPU reads/writes and loader writes.
// Read data returns two cycles after the grant cycle and is steered to its port by a pipeline tag.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int KB     = 64,
    parameter int STARVE = 8,
    localparam int AW    = $clog2(KB * 1024)
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic          vack,
    output logic          vvalid,
    output logic [7:0]    vq,
    input  logic          creq,
    input  logic          cwe,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cd,
    output logic          cack,
    output logic          cvalid,
    output logic [7:0]    cq,
    input  logic          lreq,
    input  logic [AW-1:0] la,
    input  logic [7:0]    ld,
    output logic          lack,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q
);
    localparam int CW = $clog2(STARVE + 1);

    state_t        r_state, w_next;
    logic          r_arm;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_tag;
    logic [1:0]    w_win;
    logic          w_starve;
    logic          r_we, r_vvalid, r_cvalid;
    logic [AW-1:0] r_a;
    logic [7:0]    r_d, r_vq, r_cq;

    assign w_starve = r_cnt == CW'(STARVE);

    ram_pick u_pick (
        .i_vreq   (vreq),
        .i_creq   (creq),
        .i_lreq   (lreq),
        .i_last   (r_state),
        .i_starve (w_starve),
        .o_win    (w_win)
    );

    // The first edge after reset only arms the arbiter, so no grant is selected on it.
    always_comb begin
        w_next = IDLE;
        w_next = r_arm ? state_t'(w_win) : IDLE;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_arm    <= 1'b0;
            r_cnt    <= '0;
            r_tag    <= ID_N;
            r_we     <= 1'b0;
            r_a      <= '0;
            r_d      <= '0;
            r_vvalid <= 1'b0;
            r_cvalid <= 1'b0;
            r_vq     <= '0;
            r_cq     <= '0;
        end else begin
            r_arm <= 1'b1;
            r_cnt <= (!lreq || w_next == GL) ? '0 : (r_arm && !w_starve) ? r_cnt + 1'b1 : r_cnt;
            r_we  <= w_next == GL || (w_next == GC && cwe);
            if (w_next == GV) r_a <= va;
            else if (w_next == GC) begin
                r_a <= ca;
                r_d <= cd;
            end else if (w_next == GL) begin
                r_a <= la;
                r_d <= ld;
            end
            // Tag the read whose address the RAM captures at the end of this grant cycle.
            r_tag    <= (r_state == GV) ? ID_V : (r_state == GC && !r_we) ? ID_C : ID_N;
            r_vvalid <= r_tag == ID_V;
            r_cvalid <= r_tag == ID_C;
            if (r_tag == ID_V) r_vq <= ram_q;
            if (r_tag == ID_C) r_cq <= ram_q;
        end
    end

    assign vack   = r_state == GV;
    assign cack   = r_state == GC;
    assign lack   = r_state == GL;
    assign vvalid = r_vvalid;
    assign cvalid = r_cvalid;
    assign vq     = r_vq;
    assign cq     = r_cq;
    assign ram_we = r_we;
    assign ram_a  = r_a;
    assign ram_d  = r_d;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench; reads push expected data from a shadow memory at ack, valids pop and compare.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;
    localparam int AW = 16;

    logic          clock = 0, reset = 0;
    logic          vreq = 0, creq = 0, cwe = 0, lreq = 0;
    logic [AW-1:0] va = '0, ca = '0, la = '0;
    logic [7:0]    cd = '0, ld = '0, ram_q = '0;
    logic          vack, vvalid, cack, cvalid, lack, ram_we;
    logic [7:0]    vq, cq, ram_d;
    logic [AW-1:0] ram_a;

    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];
    int n_vec = 0, n_bad = 0, cyc = 0;
    bit rec = 0;
    logic [1:0] acks[$];
    logic [7:0] vexp[$], cexp[$];
    int vcyc[$], ccyc[$];

    always #5 clock = ~clock;

    ram_arbiter dut (
        .clock(clock), .reset(reset),
        .vreq(vreq), .va(va), .vack(vack), .vvalid(vvalid), .vq(vq),
        .creq(creq), .cwe(cwe), .ca(ca), .cd(cd), .cack(cack), .cvalid(cvalid), .cq(cq),
        .lreq(lreq), .la(la), .ld(ld), .lack(lack),
        .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
    );

    always @(posedge clock) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            vexp.delete(); vcyc.delete(); cexp.delete(); ccyc.delete();
        end else begin
            if (vack || cack || lack) begin
                chk("one_ack", $countones({vack, cack, lack}), 1);
                if (rec) acks.push_back(vack ? ID_V : cack ? ID_C : ID_L);
            end else chk("idle_we", ram_we, 0);
            if (vack) begin
                chk("v_a", ram_a, va);
                chk("v_we", ram_we, 0);
                vexp.push_back(shadow[va]);
                vcyc.push_back(cyc);
            end
            if (cack) begin
                chk("c_a", ram_a, ca);
                chk("c_we", ram_we, cwe);
                if (cwe) begin
                    chk("c_d", ram_d, cd);
                    shadow[ca] = cd;
                end else begin
                    cexp.push_back(shadow[ca]);
                    ccyc.push_back(cyc);
                end
            end
            if (lack) begin
                chk("l_a", ram_a, la);
                chk("l_we", ram_we, 1);
                chk("l_d", ram_d, ld);
                shadow[la] = ld;
            end
            if (vvalid) begin
                if (vexp.size() == 0) chk("v_spurious", vvalid, 0);
                else begin
                    chk("vq", vq, vexp.pop_front());
                    chk("v_lat", cyc, vcyc.pop_front() + 2);
                end
            end
            if (cvalid) begin
                if (cexp.size() == 0) chk("c_spurious", cvalid, 0);
                else begin
                    chk("cq", cq, cexp.pop_front());
                    chk("c_lat", cyc, ccyc.pop_front() + 2);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_v(input logic [AW-1:0] a);
        bit got = 0;
        @(negedge clock);
        va = a; vreq = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = vack;
        end
        vreq = 0;
        chk("v_grant", got, 1);
    endtask

    task automatic do_c(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        bit got = 0;
        @(negedge clock);
        cwe = w; ca = a; cd = d; creq = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = cack;
        end
        creq = 0;
        chk("c_grant", got, 1);
    endtask

    task automatic wait_acks(input int n, input int budget);
        for (int i = 0; i < budget && acks.size() < n; i++) @(negedge clock);
        vreq = 0; creq = 0; lreq = 0; rec = 0;
        chk("ack_count", acks.size() >= n, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem[16'h1234] = 8'hA5; shadow[16'h1234] = 8'hA5;
        mem[16'h0100] = 8'h11; shadow[16'h0100] = 8'h11;
        mem[16'h0200] = 8'h22; shadow[16'h0200] = 8'h22;
        #1 reset = 1;
        vreq = 1; creq = 1; lreq = 1; va = 16'h1234;
        repeat (3) @(negedge clock);
        chk("rst_vack", vack, 0);
        chk("rst_cack", cack, 0);
        chk("rst_lack", lack, 0);
        chk("rst_vvalid", vvalid, 0);
        chk("rst_cvalid", cvalid, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_a", ram_a, 0);
        chk("rst_d", ram_d, 0);
        chk("rst_vq", vq, 0);
        chk("rst_cq", cq, 0);
        // Video alone at 0x1234: arming edge first, then the grant.
        creq = 0; lreq = 0;
        reset = 0;
        @(negedge clock);
        chk("arm_no_vack", vack, 0);
        @(negedge clock);
        chk("first_vack", vack, 1);
        vreq = 0;
        idle(5);
        chk("vq_hold", vq, 8'hA5);
        // CPU write then read back.
        do_c(1, 16'h4000, 8'h3C);
        idle(4);
        do_c(0, 16'h4000, 8'h00);
        idle(5);
        chk("cq_hold", cq, 8'h3C);
        // Video and CPU contend: strict alternation.
        va = 16'h0100; ca = 16'h0200; cwe = 0;
        acks.delete(); rec = 1; vreq = 1; creq = 1;
        wait_acks(8, 40);
        for (int i = 0; i < 8 && i < acks.size(); i++) chk("vc_seq", acks[i], (i % 2) ? ID_C : ID_V);
        idle(5);
        // All three contend: loader promoted once its counter saturates.
        la = 16'h0300; ld = 8'h77;
        acks.delete(); rec = 1; vreq = 1; creq = 1; lreq = 1;
        wait_acks(20, 60);
        for (int i = 0; i < 20 && i < acks.size(); i++)
            chk("vcl_seq", acks[i], (i == 9 || i == 19) ? ID_L : (i % 2) ? ID_C : ID_V);
        idle(5);
        do_v(16'h0300);
        idle(5);
        // Reset during the cycle after vack aborts the read.
        do_v(16'h1234);
        @(posedge clock);
        #1 reset = 1;
        @(negedge clock);
        chk("abort_vvalid", vvalid, 0);
        chk("abort_we", ram_we, 0);
        chk("abort_vack", vack, 0);
        @(negedge clock);
        reset = 0;
        idle(6);
        chk("abort_vq", vq, 0);
        chk("v_drain", vexp.size(), 0);
        chk("c_drain", cexp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
